// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the program counter of the pipelined core and picks the next fetch
//   address each cycle. The choices are a sequential increment, a branch or
//   jump redirect, a load-use stall, or a halt drain. It also drives the
//   IF/ID valid, flush and hold controls, so programs do not need NOP padding
//   for bubble slots.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             pulse: leave IDLE/HALTED and fetch from RESET_PC
//   stall_req         load-use hazard: hold pc and IF/ID this cycle
//   halt_seen         decode holds a valid HALT
//   redirect_valid    EX resolved a taken branch/jal/jalr
//   redirect_target   absolute word address of the redirect
//   pc, pc_plus1      registered fetch address and its link value
//   fetch_valid       registered: the instruction at pc is live
//   hold, flush       combinational IF/ID controls
//   halted            registered: the core has stopped
//   fault             sticky: pc tried to leave 0..IMEM_DEPTH-1
//   run_cycles        saturating count of RUN/REFILL/DRAIN cycles
module fetch_sequencer #(
  parameter int IMEM_DEPTH    = 64,
  parameter int RESET_PC      = 0,
  parameter int REFILL_CYCLES = 0,
  parameter int DRAIN_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall_req,
  input  logic        halt_seen,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus1,
  output logic        fetch_valid,
  output logic        hold,
  output logic        flush,
  output logic        halted,
  output logic        fault,
  output logic [31:0] run_cycles
);

  typedef enum logic [2:0] {IDLE, RUN, REFILL, DRAIN, HALTED} state_t;

  localparam logic [31:0] RESET_PC_W = 32'(RESET_PC);
  localparam logic [31:0] DEPTH_W    = 32'(IMEM_DEPTH);
  localparam logic [31:0] LAST_PC_W  = 32'(IMEM_DEPTH - 1);
  localparam logic [2:0]  REFILL_LD  = 3'(REFILL_CYCLES);
  localparam logic [2:0]  DRAIN_LD   = 3'(DRAIN_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus1_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        fetch_valid_q, halted_q;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        active;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    fault_d      = fault_q;
    run_cycles_d = run_cycles_q;
    flush        = 1'b0;
    hold         = 1'b0;
    active       = (state_q == RUN) || (state_q == REFILL) || (state_q == DRAIN);

    if (active && (run_cycles_q != 32'hFFFF_FFFF)) begin
      run_cycles_d = run_cycles_q + 32'd1;
    end

    // A redirect has the same effect in RUN, REFILL and DRAIN. In DRAIN it
    // comes from an instruction older than the HALT, so it cancels the halt.
    if (active && redirect_valid) begin
      flush = 1'b1;
      if (redirect_target >= DEPTH_W) begin
        fault_d = 1'b1;
        state_d = HALTED;
      end else begin
        pc_d = redirect_target;
        if (REFILL_CYCLES > 0) begin
          state_d = REFILL;
          cnt_d   = REFILL_LD;
        end else begin
          state_d = RUN;
        end
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            pc_d    = RESET_PC_W;
          end
        end
        RUN: begin
          if (stall_req) begin
            hold = 1'b1;
          end else if (halt_seen) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_LD;
          end else if (pc_q == LAST_PC_W) begin
            fault_d = 1'b1;
            state_d = HALTED;
          end else begin
            pc_d = pc_q + 32'd1;
          end
        end
        REFILL: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        DRAIN: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = HALTED;
        end
        HALTED: begin
          if (start) begin
            state_d = RUN;
            pc_d    = RESET_PC_W;
            fault_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC_W;
      pc_plus1_q    <= RESET_PC_W + 32'd1;
      cnt_q         <= 3'd0;
      fault_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      run_cycles_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_plus1_q    <= pc_d + 32'd1;
      cnt_q         <= cnt_d;
      fault_q       <= fault_d;
      // Status outputs are registered from the next state, so they line up
      // with the state they describe.
      fetch_valid_q <= (state_d == RUN);
      halted_q      <= (state_d == HALTED);
      run_cycles_q  <= run_cycles_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus1    = pc_plus1_q;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. For each cycle the driver applies inputs
// and pushes the expected outputs from a behavioural model into a queue. The
// monitor samples the DUT mid-cycle and checks it against the queue.
module tb_fetch_sequencer;

  localparam int DEPTH  = 64;
  localparam int RPC    = 0;
  localparam int REFILL = 2;
  localparam int DRAIN  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall_req = 1'b0;
  logic        halt_seen = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] pc, pc_plus1, run_cycles;
  logic        fetch_valid, hold, flush, halted, fault;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .IMEM_DEPTH(DEPTH), .RESET_PC(RPC), .REFILL_CYCLES(REFILL), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall_req(stall_req),
    .halt_seen(halt_seen), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .pc(pc), .pc_plus1(pc_plus1),
    .fetch_valid(fetch_valid), .hold(hold), .flush(flush), .halted(halted),
    .fault(fault), .run_cycles(run_cycles)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] run_cycles;
    logic        fetch_valid;
    logic        hold;
    logic        flush;
    logic        halted;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Model: the core is idle, fetching, waiting out refill bubbles, draining,
  // or stopped. A remaining-cycle count ends each bubble or drain phase.
  typedef enum {M_IDLE, M_FETCH, M_BUBBLE, M_DRAIN, M_STOP} mode_t;
  mode_t           m_mode = M_IDLE;
  int              m_left = 0;
  logic [31:0]     m_pc = RPC;
  logic            m_fault = 1'b0;
  longint unsigned m_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.pc          = m_pc;
    e.pc_plus1    = m_pc + 32'd1;
    e.run_cycles  = m_cycles[31:0];
    e.fetch_valid = (m_mode == M_FETCH);
    e.halted      = (m_mode == M_STOP);
    e.fault       = m_fault;
    e.hold        = 1'b0;
    e.flush       = 1'b0;
    return e;
  endfunction

  task automatic reset_cycle();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stall_req = 1'b0; halt_seen = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'd0;
    m_mode = M_IDLE; m_left = 0; m_pc = RPC; m_fault = 1'b0; m_cycles = 0;
    exp_q.push_back(snapshot());
  endtask

  task automatic apply(input logic s, input logic st, input logic h,
                       input logic r, input logic [31:0] t);
    exp_t e;
    bit busy;
    @(negedge clk);
    rst_n = 1'b1; start = s; stall_req = st; halt_seen = h;
    redirect_valid = r; redirect_target = t;
    e = snapshot();
    busy = (m_mode == M_FETCH) || (m_mode == M_BUBBLE) || (m_mode == M_DRAIN);
    if (busy && m_cycles < 64'hFFFF_FFFF) m_cycles++;
    if (m_mode == M_IDLE) begin
      if (s) begin m_mode = M_FETCH; m_pc = RPC; end
    end else if (m_mode == M_STOP) begin
      if (s) begin m_mode = M_FETCH; m_pc = RPC; m_fault = 1'b0; end
    end else if (r) begin
      e.flush = 1'b1;
      if (t >= DEPTH) begin
        m_fault = 1'b1; m_mode = M_STOP;
      end else begin
        m_pc = t;
        if (REFILL > 0) begin m_mode = M_BUBBLE; m_left = REFILL; end
        else m_mode = M_FETCH;
      end
    end else if (m_mode == M_BUBBLE) begin
      m_left--;
      if (m_left == 0) m_mode = M_FETCH;
    end else if (m_mode == M_DRAIN) begin
      m_left--;
      if (m_left == 0) m_mode = M_STOP;
    end else if (st) begin
      e.hold = 1'b1;
    end else if (h) begin
      m_mode = M_DRAIN; m_left = DRAIN;
    end else if (m_pc == DEPTH - 1) begin
      m_fault = 1'b1; m_mode = M_STOP;
    end else begin
      m_pc = m_pc + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 32'd0);
  endtask

  // Monitor: samples 2 time units after the falling edge. By then the
  // registered outputs have settled from the previous rising edge, and
  // flush/hold have settled for this cycle's inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc",          pc,                 e.pc);
        check("pc_plus1",    pc_plus1,           e.pc_plus1);
        check("run_cycles",  run_cycles,         e.run_cycles);
        check("fetch_valid", 32'(fetch_valid),   32'(e.fetch_valid));
        check("hold",        32'(hold),          32'(e.hold));
        check("flush",       32'(flush),         32'(e.flush));
        check("halted",      32'(halted),        32'(e.halted));
        check("fault",       32'(fault),         32'(e.fault));
        cyc++;
      end
    end
  end

  initial begin
    reset_cycle();
    // IDLE ignores everything except start.
    apply(0, 1, 1, 1, 32'd5);
    apply(0, 0, 1, 1, 32'd70);
    apply(1, 0, 0, 0, 32'd0);
    idle_n(6);                               // pc 0..6
    apply(0, 0, 0, 1, 32'd20);               // redirect at pc 6
    idle_n(4);                               // 2 bubbles, then pc 20, 21
    apply(0, 0, 0, 1, 32'd9);
    idle_n(2);
    apply(0, 1, 0, 0, 32'd0);                // stall at pc 9
    apply(0, 1, 0, 0, 32'd0);
    idle_n(2);
    apply(0, 0, 0, 1, 32'd5);
    idle_n(2);
    apply(0, 0, 1, 0, 32'd0);                // halt at pc 5
    apply(0, 1, 1, 0, 32'd0);                // ignored in DRAIN
    idle_n(4);
    apply(0, 1, 1, 1, 32'd3);                // ignored in HALTED
    apply(1, 0, 0, 0, 32'd0);                // restart at pc 0
    idle_n(3);
    apply(0, 0, 1, 0, 32'd0);                // halt
    apply(1, 0, 0, 0, 32'd0);                // start ignored in DRAIN
    apply(0, 0, 0, 1, 32'd14);               // redirect in 2nd drain cycle
    idle_n(4);
    apply(0, 0, 0, 1, 32'd64);               // out of range -> fault
    idle_n(2);
    apply(1, 0, 0, 0, 32'd0);
    idle_n(2);
    apply(0, 0, 0, 1, 32'd30);
    apply(0, 0, 0, 0, 32'd0);
    reset_cycle();                           // reset mid-REFILL
    idle_n(2);
    apply(1, 0, 0, 0, 32'd0);
    apply(0, 0, 0, 1, 32'd62);
    idle_n(5);                               // 62, 63, then sequential fault
    apply(1, 0, 0, 0, 32'd0);
    idle_n(2);
    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic s, st, h, r;
      logic [31:0] t;
      s  = ($urandom_range(0, 99) < 10);
      st = ($urandom_range(0, 99) < 15);
      h  = ($urandom_range(0, 99) < 5);
      r  = ($urandom_range(0, 99) < 10);
      t  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(64, 70))
                                       : 32'($urandom_range(0, 63));
      apply(s, st, h, r, t);
    end
    idle_n(2);
    @(negedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
